// File: rtl/tt_um_serial_subtractor_if.sv
// Pin frame bundle for the serial subtractor: dedicated in/out buses plus bidirectional pins.
interface tt_um_serial_subtractor_if;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport slave (
      input  ui_in,
      input  uio_in,
      output uo_out,
      output uio_out,
      output uio_oe
   );

   modport master (
      output ui_in,
      output uio_in,
      input  uo_out,
      input  uio_out,
      input  uio_oe
   );
endinterface

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial A-B subtractor, LSB first, one bit per clock through a borrow flip-flop.
// Optional macro SUBTRACTOR_BORROW_IN_EN seeds the borrow from uio_in[3] on start.
module tt_um_serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   tt_um_serial_subtractor_if.slave      pins
);

   localparam int unsigned BUS_W = 8;
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_a, w_a_nxt;
   logic [WIDTH-1:0]   r_b, w_b_nxt;
   logic [WIDTH-1:0]   r_sa, w_sa_nxt;
   logic [WIDTH-1:0]   r_sb, w_sb_nxt;
   logic [WIDTH-1:0]   r_res, w_res_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_borrow, w_borrow_nxt;
   logic [BUS_W-1:0]   r_uo, w_uo_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;
   logic               r_bout, w_bout_nxt;
   logic               r_zero, w_zero_nxt;

   logic               w_load_a;
   logic               w_load_b;
   logic               w_start;
   logic               w_bin;
   logic               w_a0;
   logic               w_b0;
   logic               w_d;
   logic               w_br;
   logic               w_last;
   logic [WIDTH-1:0]   w_res_sh;
   logic [WIDTH-1:0]   w_operand;
   logic               w_unused;

   assign w_load_a  = pins.uio_in[0];
   assign w_load_b  = pins.uio_in[1];
   assign w_start   = pins.uio_in[2];
   assign w_operand = pins.ui_in[WIDTH-1:0];

`ifdef SUBTRACTOR_BORROW_IN_EN
   assign w_bin = pins.uio_in[3];
`else
   assign w_bin = 1'b0;
`endif

   // Full-subtractor cell on the current LSBs; the new difference bit enters at the top.
   assign w_a0     = r_sa[0];
   assign w_b0     = r_sb[0];
   assign w_d      = w_a0 ^ w_b0 ^ r_borrow;
   assign w_br     = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
   assign w_res_sh = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      w_state_nxt  = r_state;
      w_a_nxt      = r_a;
      w_b_nxt      = r_b;
      w_sa_nxt     = r_sa;
      w_sb_nxt     = r_sb;
      w_res_nxt    = r_res;
      w_cnt_nxt    = r_cnt;
      w_borrow_nxt = r_borrow;
      w_uo_nxt     = r_uo;
      w_done_nxt   = r_done;
      w_bout_nxt   = r_bout;
      w_zero_nxt   = r_zero;

      case (r_state)
         S_IDLE: begin
            // start takes priority over loads so a run always uses the stored operands
            if (w_start) begin
               w_sa_nxt     = r_a;
               w_sb_nxt     = r_b;
               w_res_nxt    = '0;
               w_cnt_nxt    = '0;
               w_borrow_nxt = w_bin;
               w_done_nxt   = 1'b0;
               w_state_nxt  = S_RUN;
            end else begin
               if (w_load_a) begin
                  w_a_nxt = w_operand;
               end
               if (w_load_b) begin
                  w_b_nxt = w_operand;
               end
               if (w_load_a || w_load_b) begin
                  w_done_nxt = 1'b0;
               end
            end
         end

         S_RUN: begin
            w_res_nxt    = w_res_sh;
            w_sa_nxt     = r_sa >> 1;
            w_sb_nxt     = r_sb >> 1;
            w_borrow_nxt = w_br;
            w_cnt_nxt    = r_cnt + CNT_W'(1);
            if (w_last) begin
               w_uo_nxt    = BUS_W'(w_res_sh);
               w_bout_nxt  = w_br;
               w_zero_nxt  = (w_res_sh == '0);
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt == S_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_sa     <= '0;
         r_sb     <= '0;
         r_res    <= '0;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_uo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_bout   <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_a      <= w_a_nxt;
         r_b      <= w_b_nxt;
         r_sa     <= w_sa_nxt;
         r_sb     <= w_sb_nxt;
         r_res    <= w_res_nxt;
         r_cnt    <= w_cnt_nxt;
         r_borrow <= w_borrow_nxt;
         r_uo     <= w_uo_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_bout   <= w_bout_nxt;
         r_zero   <= w_zero_nxt;
      end
   end

   assign pins.uo_out  = r_uo;
   assign pins.uio_out = {r_zero, r_bout, r_done, r_busy, 4'b0000};
   assign pins.uio_oe  = 8'hF0;

   assign w_unused = ^{ena, pins.ui_in, pins.uio_in};

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Scoreboard bench for the serial subtractor: arithmetic reference model feeds a queue, a monitor checks on done.
module tb_tt_um_serial_subtractor;

   localparam int unsigned WIDTH = 8;
   localparam int          MODV  = 1 << WIDTH;

   typedef struct packed {
      logic [7:0] diff;
      logic       bout;
      logic       zero;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic ena   = 1'b1;

   tt_um_serial_subtractor_if pins ();

   tt_um_serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .pins  (pins)
   );

   always #5 clk = ~clk;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference state: stored operands and the remaining run length, in plain integers.
   int   model_a   = 0;
   int   model_b   = 0;
   int   run_left  = 0;
   logic exp_busy  = 1'b0;
   logic exp_done  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t ref_sub(input int a, input int b, input int bin);
      exp_t e;
      int   r;
      r = a - b - bin;
      if (r < 0) r += MODV;
      e.diff = 8'(r);
      e.bout = (a < b + bin);
      e.zero = (r == 0);
      return e;
   endfunction

   task automatic model_edge(input logic [7:0] ui, input logic [7:0] uio);
      logic bin;
      bin = uio[3];
`ifndef SUBTRACTOR_BORROW_IN_EN
      bin = 1'b0;
`endif
      if (run_left > 0) begin
         run_left--;
         if (run_left == 0) exp_done = 1'b1;
      end else if (uio[2]) begin
         sb_q.push_back(ref_sub(model_a, model_b, int'(bin)));
         run_left = WIDTH;
         exp_done = 1'b0;
      end else begin
         if (uio[0]) model_a = int'(ui) % MODV;
         if (uio[1]) model_b = int'(ui) % MODV;
         if (uio[0] || uio[1]) exp_done = 1'b0;
      end
      exp_busy = (run_left > 0);
   endtask

   task automatic step(input logic [7:0] ui, input logic [7:0] uio);
      pins.ui_in  = ui;
      pins.uio_in = uio;
      @(posedge clk);
      model_edge(ui, uio);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(8'h00, 8'h00);
   endtask

   task automatic sub_run(input logic [7:0] a, input logic [7:0] b, input logic bin);
      step(a, 8'h01);
      step(b, 8'h02);
      step(8'h00, {4'b0, bin, 3'b100});
      idle(WIDTH);
   endtask

   // Monitor: flags each cycle, and pops the scoreboard whenever done rises.
   logic       prev_done = 1'b0;
   logic [7:0] hold      = 8'h00;
   exp_t       got;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_done = 1'b0;
         hold      = 8'h00;
      end else begin
         check("busy", 32'(pins.uio_out[4]), 32'(exp_busy));
         check("done", 32'(pins.uio_out[5]), 32'(exp_done));
         check("uio_low", 32'(pins.uio_out[3:0]), 32'h0);
         check("uio_oe", 32'(pins.uio_oe), 32'hF0);
         if (pins.uio_out[4]) check("uo_hold", 32'(pins.uo_out), 32'(hold));
         if (pins.uio_out[5] && !prev_done) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL done_unexpected: got done=1, expected no pending result at %0t", $time);
            end else begin
               got = sb_q.pop_front();
               check("diff", 32'(pins.uo_out), 32'(got.diff));
               check("borrow_out", 32'(pins.uio_out[6]), 32'(got.bout));
               check("zero", 32'(pins.uio_out[7]), 32'(got.zero));
               hold = got.diff;
            end
         end
         prev_done = pins.uio_out[5];
      end
   end

   initial begin
      logic [7:0] r_ui;
      logic [7:0] r_uio;
      int         k;
      pins.ui_in  = 8'h00;
      pins.uio_in = 8'h00;
      rst_n       = 1'b0;
      #12;
      check("rst_uo", 32'(pins.uo_out), 32'h0);
      check("rst_uio", 32'(pins.uio_out), 32'h0);
      check("rst_oe", 32'(pins.uio_oe), 32'hF0);
      @(negedge clk);
      rst_n = 1'b1;

      sub_run(8'h05, 8'h03, 1'b0);
      sub_run(8'h03, 8'h05, 1'b0);
      sub_run(8'h80, 8'h80, 1'b0);

      // Loads and start during RUN are ignored; a rerun proves A kept its value.
      step(8'h05, 8'h01);
      step(8'h03, 8'h02);
      step(8'h00, 8'h04);
      step(8'h00, 8'h00);
      step(8'hFF, 8'h05);
      idle(WIDTH - 2);
      step(8'h00, 8'h04);
      idle(WIDTH);

      // Start with a load in the same IDLE cycle: start wins.
      step(8'h09, 8'h05);
      idle(WIDTH);
      step(8'h00, 8'h04);
      idle(WIDTH);

      // Reset during RUN discards everything.
      step(8'h00, 8'h04);
      idle(4);
      rst_n = 1'b0;
      #1;
      check("midrst_uo", 32'(pins.uo_out), 32'h0);
      check("midrst_uio", 32'(pins.uio_out), 32'h0);
      check("midrst_oe", 32'(pins.uio_oe), 32'hF0);
      model_a  = 0;
      model_b  = 0;
      run_left = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(8'h00, 8'h04);
      idle(WIDTH);
      sub_run(8'h10, 8'h01, 1'b0);

`ifdef SUBTRACTOR_BORROW_IN_EN
      sub_run(8'h05, 8'h03, 1'b1);
      sub_run(8'h00, 8'h00, 1'b1);
`endif

      // start held high: back-to-back runs every WIDTH+1 cycles.
      for (int i = 0; i < 3 * (WIDTH + 1); i++) step(8'($urandom), {4'b0, 1'($urandom), 3'b100});

      // Random level strobes, biased so most runs see fresh operands.
      for (int i = 0; i < 400; i++) begin
         k     = int'($urandom_range(0, 9));
         r_ui  = 8'($urandom);
         r_uio = 8'($urandom) & 8'hF8;
         if (k < 3) r_uio[0] = 1'b1;
         else if (k < 6) r_uio[1] = 1'b1;
         else if (k < 8) r_uio[2] = 1'b1;
         if ($urandom_range(0, 3) == 0) r_uio[0] = 1'b1;
         step(r_ui, r_uio);
      end

      idle(WIDTH + 2);
      check("sb_drain", 32'(sb_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tt_um_serial_subtractor.md
Name: tt_um_serial_subtractor

Overview:
- Bit-serial subtractor that computes A − B one bit per clock, LSB first, using a half/full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation companion to the team's combinational half adder and uses the same pin frame.
- Operands are loaded from the dedicated input bus with strobes on the bidirectional pins.
- The difference appears on the dedicated outputs; status flags appear on the upper bidirectional pins.

Parameters:
- WIDTH, 8, operand/result width in bits. Legal range 1..8. Result bits above WIDTH-1 read 0.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  design-powered indicator; ignored
- ui_in  input  8  operand data bus
- uo_out  output  8  difference result register
- uio_in  input  8  [0] load_a, [1] load_b, [2] start, [3] borrow_in (optional feature only), [7:4] unused
- uio_out  output  8  [3:0] = 0, [4] busy, [5] done, [6] borrow_out, [7] zero
- uio_oe  output  8  constant 8'hF0

Behaviour:
- Clocking and reset: one clock, clk, rising edge. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; A, B, shift registers, count, borrow, result = 0; uo_out=0; busy=0; done=0; borrow_out=0; zero=0. uio_oe stays 8'hF0 at all times.
- All strobes are level-sampled at each rising edge. There is no edge detection.

State machine, IDLE:
- load_a=1: A <= ui_in[WIDTH-1:0].
- load_b=1: B <= ui_in[WIDTH-1:0].
- Either load clears done.
- start=1: copy A and B into the working shift registers, borrow <= 0, count <= 0, done <= 0, go to RUN.
- If start is asserted together with any load in the same cycle, start wins. The loads that cycle are ignored, and the computation uses the previously stored A and B.

State machine, RUN:
- Each edge processes bit a0/b0/br:
  - d = a0 ^ b0 ^ br
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
- d shifts into the result shift register at bit WIDTH-1; the A and B shift registers shift right; count increments.
- On the edge that processes bit WIDTH-1:
  - result register → uo_out
  - borrow_out <= final br'
  - zero <= (difference == 0)
  - done <= 1
  - go to IDLE
- start, load_a and load_b are ignored in RUN. The stored A and B are not disturbed.

Outputs and timing:
- busy = (state == RUN). It is registered, so it is high for exactly WIDTH cycles.
- Latency: start sampled at edge k → done, uo_out, borrow_out and zero valid after edge k+WIDTH.
- uo_out, borrow_out and zero hold their previous values throughout RUN. They update only at completion.
- done is sticky until the next accepted start or any load in IDLE.

Arithmetic:
- Modulo 2^WIDTH.
- borrow_out = 1 iff A < B, unsigned (with the optional feature: iff A < B + borrow_in).

Boundary conditions:
- start held high continuously: after completion, one IDLE cycle, then a new run is accepted. Back-to-back period is WIDTH+1 cycles.
- Reset asserted mid-RUN: immediate return to reset values. The partial result is discarded and the A/B registers are cleared.
- A == B: difference 0, zero=1, borrow_out=0.

Optional Feature:
- Macro: SUBTRACTOR_BORROW_IN_EN.
- Defined: uio_in[3] is sampled together with an accepted start and initialises the borrow flip-flop. The result is A − B − borrow_in, which allows multi-byte chaining by feeding the previous borrow_out externally.
- Not defined: the borrow flip-flop always initialises to 0 and uio_in[3] is ignored.

Test Plan:
- Reset, then load_a=0x05, load_b=0x03, start → busy high 8 cycles; after edge k+8: uo_out=0x02, done=1, borrow_out=0, zero=0.
- A=0x03, B=0x05, start → uo_out=0xFE, borrow_out=1, zero=0. A=0x80, B=0x80 → uo_out=0x00, zero=1, borrow_out=0.
- During RUN of 0x05−0x03: pulse load_a=0xFF and start → ignored; result 0x02. The next start with no new loads yields 0x02 again, proving A was unchanged.
- Assert rst_n=0 at RUN cycle 4 → all outputs 0 immediately, state IDLE. After release, load 0x10/0x01 and run → uo_out=0x0F.
- start with load_a=0x09 in the same IDLE cycle (previous A=0x05, B=0x03) → result 0x02; afterwards A=0x05 still.
- With SUBTRACTOR_BORROW_IN_EN: A=0x05, B=0x03, borrow_in=1 → uo_out=0x01. Then A=0x00, B=0x00, borrow_in=1 → uo_out=0xFF, borrow_out=1.
